image_row_window_sequencer: RTL and testbench
=============================================

// Module: image_row_window_sequencer
// PURPOSE
//  Sequences a full-image pass through the coprocessor's row-banked image store (NUM_BANKS banks x ROWS_PER_BANK rows).
//  Reads source rows in order and presents a 3-row sliding window (top/mid/bot) to the filter datapath over valid/ready.
//  Accepts one in-order result row per window and writes it to the destination bank set.
//  Sits between the coprocessor command decoder (start/done) and the image banks plus filter pipeline.
// PARAMETERS
//  ROW_W          3072  bits per image row (one bank entry)
//  ROWS_PER_BANK  32    rows held per bank; bank address width AW = $clog2(ROWS_PER_BANK)
//  NUM_BANKS      3     banks per image; max rows MAXR = NUM_BANKS*ROWS_PER_BANK (96)
// PORTS
//  clk          in   1           single clock
//  rst_n        in   1           asynchronous active-low reset
//  start        in   1           one-cycle pulse begins a pass; ignored while busy
//  cfg_rows     in   7           image height, sampled on start; legal 0..MAXR
//  busy         out  1           high from accepted start until done
//  done         out  1           one-cycle pulse after the last destination write
//  src_re       out  NUM_BANKS   one-hot read enable to source banks
//  src_raddr    out  AW          row address within the selected bank
//  src_rdata    in   NUM_BANKS*ROW_W  bank b read data at [b*ROW_W +: ROW_W]; valid 1 cycle after src_re
//  win_valid    out  1           window valid to filter
//  win_ready    in   1           filter accepts window when win_valid & win_ready
//  win_top/win_mid/win_bot  out  ROW_W  rows r-1, r, r+1 (clamped to image)
//  res_valid    in   1           filter result row valid; always accepted, in window order
//  res_data     in   ROW_W       result row
//  dst_we       out  NUM_BANKS   one-hot write enable to destination banks
//  dst_waddr    out  AW          destination row address in bank
//  dst_wdata    out  ROW_W       destination row data
// BEHAVIOUR
//  Reset: all outputs 0 (busy, done, src_re, dst_we, win_valid, addresses, window regs); FSM -> IDLE.
//  Row mapping: row n -> bank n/ROWS_PER_BANK, addr n%ROWS_PER_BANK (src and dst identical).
//  Source read latency exactly 1 cycle: src_re in cycle t, capture src_rdata at edge ending t+1.
//  FSM: IDLE -> (start & cfg_rows!=0) RD0 -> CAP0 -> RD1 -> CAP1 -> ISSUE -> SHIFT -> RDN -> CAPN -> ISSUE ... -> DRAIN -> IDLE.
//   IDLE: start & cfg_rows==0 -> done pulse next cycle, busy never rises.
//   RD0/CAP0: read row 0; CAP0 loads top=mid=row0.
//   RD1/CAP1: read row 1 into bot; if cfg_rows==1 skip read, bot=row0.
//   ISSUE: win_valid=1, window regs held stable until win_ready; on handshake r++.
//   SHIFT: top<=mid, mid<=bot; if r+1 < cfg_rows go RDN (read row r+1 into bot) else keep bot (bottom clamp) and return to ISSUE.
//   After handshake of window r=cfg_rows-1 -> DRAIN.
//   DRAIN: wait until write count == cfg_rows, then IDLE with done pulse.
//  Write path (independent of FSM): res_valid at cycle t -> dst_we/waddr/wdata registered at t+1, write count w++.
//   res_valid in IDLE or after w==cfg_rows is dropped (no write).
//  busy=1 in every non-IDLE state; done and busy never high together; done pulses exactly once per accepted start.
//  win_valid must not drop before handshake; window contents stable while win_valid & ~win_ready.
//  Reset mid-pass: async abort, all outputs 0 immediately, no done pulse; pending results discarded.
//  Simultaneous res_valid and window handshake in same cycle: both processed.
//  Counters: r, w are 7-bit; no wrap (bounded by cfg_rows <= MAXR).
// STRUCTURE
//  Package img_coproc_pkg: ROW_W, ROWS_PER_BANK, NUM_BANKS, AW, MAXR, row_t, seq_state_e enum.
//  Sub-module row_to_bank_addr (combinational row -> one-hot bank + addr), instanced for src and dst.
//  FSM, window registers and write path stay in this module.
// TESTING
//  cfg_rows=4, rows hold pattern n -> windows (0,0,1),(0,1,2),(1,2,3),(2,3,3); 4 dst writes; done once.
//  cfg_rows=96, win_ready always 1 -> rows 31->32, 63->64 read from bank 0 addr 31, bank 1 addr 0, bank 2 addr 0.
//  cfg_rows=1 -> single window (0,0,0), one src read only; cfg_rows=0 -> done 1 cycle after start, busy stays 0.
//  win_ready held low 5 cycles at r=2 -> win_valid and window values stable; no extra src reads.
//  start pulsed while busy -> ignored, cfg_rows not resampled; res_valid in IDLE -> no dst_we.
//  rst_n low during r=2 -> outputs 0 that cycle; new start afterwards completes normally.

Source files
------------

// File: rtl/image_row_window_sequencer_pkg.sv
// Shared geometry, row types and sequencer state encoding for the image coprocessor.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package img_coproc_pkg;
  localparam int ROW_W         = 3072;
  localparam int ROWS_PER_BANK = 32;
  localparam int NUM_BANKS     = 3;
  localparam int AW            = $clog2(ROWS_PER_BANK);
  localparam int MAXR          = NUM_BANKS * ROWS_PER_BANK;
  localparam int RIW           = 7;  // row index / counter width, holds 0..MAXR

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [RIW-1:0]   ridx_t;

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_CAP0, S_RD1, S_CAP1,
    S_ISSUE, S_SHIFT, S_RDN, S_CAPN, S_DRAIN
  } seq_state_e;
endpackage

// File: rtl/image_row_window_sequencer_if.sv
// Window (sequencer -> filter) and result (filter -> sequencer) bundle.
// Latency: wires only.
// Backpressure: win_valid/win_ready handshake; results have no backpressure.
interface image_row_window_sequencer_if;
  import img_coproc_pkg::*;

  logic win_valid;
  logic win_ready;
  row_t win_top;
  row_t win_mid;
  row_t win_bot;
  logic res_valid;
  row_t res_data;

  modport master (
    output win_valid, win_top, win_mid, win_bot,
    input  win_ready, res_valid, res_data
  );

  modport slave (
    input  win_valid, win_top, win_mid, win_bot,
    output win_ready, res_valid, res_data
  );
endinterface

// File: rtl/image_row_window_sequencer_row_to_bank_addr.sv
// Maps a linear image row index to a one-hot bank select and in-bank address.
// Latency: combinational.
// Backpressure: none.
module row_to_bank_addr
  import img_coproc_pkg::*;
(
  input  ridx_t                row,
  output logic [NUM_BANKS-1:0] bank_oh,
  output logic [AW-1:0]        addr
);
  localparam ridx_t RPB = ridx_t'(ROWS_PER_BANK);

  ridx_t bank_idx;

  // Divide/modulo by the bank depth, then decode the quotient to one-hot.
  always_comb begin
    bank_idx = row / RPB;
    addr     = AW'(row % RPB);
    bank_oh  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_idx == ridx_t'(b)) bank_oh[b] = 1'b1;
    end
  end
endmodule

// File: rtl/image_row_window_sequencer.sv
// Walks an image through the banked store, issuing clamped 3-row windows and writing back results.
// Latency: 1-cycle source reads; one result row lands in the destination 1 cycle after res_valid.
// Backpressure: window held stable until win_ready; results are always accepted (no backpressure).
module image_row_window_sequencer
  import img_coproc_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  ridx_t                          cfg_rows,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_BANKS-1:0]           src_re,
  output logic [AW-1:0]                  src_raddr,
  input  logic [NUM_BANKS*ROW_W-1:0]     src_rdata,
  image_row_window_sequencer_if.master   win,
  output logic [NUM_BANKS-1:0]           dst_we,
  output logic [AW-1:0]                  dst_waddr,
  output row_t                           dst_wdata
);
  seq_state_e state, state_nx;
  ridx_t rows_q, r_q, w_q, rd_row;
  row_t  top_q, mid_q, bot_q, cap_dat;
  logic  rd_en, win_vld, start_go, start_zero;
  logic [NUM_BANKS-1:0] rd_oh, wr_oh;
  logic [AW-1:0]        rd_addr, wr_addr;

  assign start_go   = (state == S_IDLE) && start && (cfg_rows != '0);
  assign start_zero = (state == S_IDLE) && start && (cfg_rows == '0);

  row_to_bank_addr u_src_map (.row(rd_row), .bank_oh(rd_oh), .addr(rd_addr));
  row_to_bank_addr u_dst_map (.row(w_q),    .bank_oh(wr_oh), .addr(wr_addr));

  assign busy          = (state != S_IDLE);
  assign src_re        = rd_en ? rd_oh : '0;
  assign src_raddr     = rd_en ? rd_addr : '0;
  assign win.win_valid = win_vld;
  assign win.win_top   = top_q;
  assign win.win_mid   = mid_q;
  assign win.win_bot   = bot_q;

  // Pick the returning bank's data; the row index is unchanged between RD* and CAP*.
  always_comb begin
    cap_dat = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_oh[b]) cap_dat = cap_dat | src_rdata[b*ROW_W +: ROW_W];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode plus read-request and window-valid outputs.
  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    rd_row   = '0;
    win_vld  = 1'b0;
    case (state)
      S_IDLE:  if (start_go) state_nx = S_RD0;
      S_RD0:   begin rd_en = 1'b1; state_nx = S_CAP0; end
      S_CAP0:  state_nx = S_RD1;
      S_RD1:   begin rd_row = 7'd1; rd_en = (rows_q > 7'd1); state_nx = S_CAP1; end
      S_CAP1:  begin rd_row = 7'd1; state_nx = S_ISSUE; end
      S_ISSUE: begin
        win_vld = 1'b1;
        if (win.win_ready) state_nx = (r_q == rows_q - 7'd1) ? S_DRAIN : S_SHIFT;
      end
      S_SHIFT: state_nx = ((r_q + 7'd1) < rows_q) ? S_RDN : S_ISSUE;
      S_RDN:   begin rd_row = r_q + 7'd1; rd_en = 1'b1; state_nx = S_CAPN; end
      S_CAPN:  begin rd_row = r_q + 7'd1; state_nx = S_ISSUE; end
      S_DRAIN: if (w_q == rows_q) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Window registers, row counter and latched image height.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q <= '0;
      r_q    <= '0;
      top_q  <= '0;
      mid_q  <= '0;
      bot_q  <= '0;
    end else begin
      case (state)
        S_IDLE:  if (start_go) begin rows_q <= cfg_rows; r_q <= '0; end
        S_CAP0:  begin top_q <= cap_dat; mid_q <= cap_dat; end
        S_CAP1:  bot_q <= (rows_q > 7'd1) ? cap_dat : mid_q;
        S_ISSUE: if (win.win_ready) r_q <= r_q + 7'd1;
        S_SHIFT: begin top_q <= mid_q; mid_q <= bot_q; end
        S_CAPN:  bot_q <= cap_dat;
        default: ;
      endcase
    end
  end

  // Completion pulse: zero-height start, or all results written while draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= start_zero || ((state == S_DRAIN) && (w_q == rows_q));
  end

  // Result write-back runs alongside the FSM; surplus or idle results are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_we    <= '0;
      dst_waddr <= '0;
      dst_wdata <= '0;
      w_q       <= '0;
    end else begin
      dst_we <= '0;
      if (state == S_IDLE) begin
        if (start_go) w_q <= '0;
      end else if (win.res_valid && (w_q < rows_q)) begin
        dst_we    <= wr_oh;
        dst_waddr <= wr_addr;
        dst_wdata <= win.res_data;
        w_q       <= w_q + 7'd1;
      end
    end
  end
endmodule

// File: tb/tb_image_row_window_sequencer.sv
// Scoreboard bench: expected reads, windows and writes are queued by stimulus; monitors pop and compare.
module tb_image_row_window_sequencer;
  import img_coproc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start = 1'b0;
  ridx_t cfg_rows = '0;
  logic busy, done;
  logic [NUM_BANKS-1:0] src_re, dst_we;
  logic [AW-1:0] src_raddr, dst_waddr;
  logic [NUM_BANKS*ROW_W-1:0] src_rdata = '0;
  row_t dst_wdata;

  image_row_window_sequencer_if wif();

  image_row_window_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows),
    .busy(busy), .done(done), .src_re(src_re), .src_raddr(src_raddr),
    .src_rdata(src_rdata), .win(wif), .dst_we(dst_we), .dst_waddr(dst_waddr),
    .dst_wdata(dst_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {int t; int m; int b;} win_t;

  int checks = 0;
  int errors = 0;
  win_t exp_win[$];
  int exp_rd[$];
  int exp_wr[$];
  int pend[$];
  int done_cnt = 0, dst_cnt = 0, hs_cnt = 0;
  int stall_at = -1, stall_len = 0, stall_done = 0;
  logic inject = 1'b0;
  logic stalled = 1'b0;
  row_t sv_t, sv_m, sv_b;

  function automatic row_t row_pat(input int n);
    row_t v;
    for (int i = 0; i < ROW_W/32; i++) v[i*32 +: 32] = {8'(i), 8'hC3, 16'(n)};
    return v;
  endfunction

  function automatic row_t res_pat(input int n);
    return ~row_pat(n);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_eq(input string nm, input row_t act, input row_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got_lo=%h want_lo=%h", nm, act[31:0], exp[31:0]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Source bank model: 1-cycle read latency.
  always @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++)
      if (src_re[b]) src_rdata[b*ROW_W +: ROW_W] <= row_pat(b*ROWS_PER_BANK + int'(src_raddr));
  end

  // Source read monitor.
  always @(negedge clk) begin
    if (src_re != '0) begin
      if (exp_rd.size() == 0) chk("src_extra_read", 64'(src_re), 64'd0);
      else begin
        int n;
        n = exp_rd.pop_front();
        chk("src_re", 64'(src_re), 64'd1 << (n / ROWS_PER_BANK));
        chk("src_raddr", 64'(src_raddr), 64'(n % ROWS_PER_BANK));
      end
    end
  end

  // Destination write monitor.
  always @(negedge clk) begin
    if (dst_we != '0) begin
      dst_cnt++;
      if (exp_wr.size() == 0) chk("dst_extra_write", 64'(dst_we), 64'd0);
      else begin
        int k;
        k = exp_wr.pop_front();
        chk("dst_we", 64'(dst_we), 64'd1 << (k / ROWS_PER_BANK));
        chk("dst_waddr", 64'(dst_waddr), 64'(k % ROWS_PER_BANK));
        chk_eq("dst_wdata", dst_wdata, res_pat(k));
      end
    end
  end

  // Done monitor.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      chk("done_busy_excl", 64'(busy), 64'd0);
    end
  end

  // Filter model: ready generation, window check, stall stability, result return.
  always @(negedge clk) begin
    if (stalled) begin
      chk("hold_valid", 64'(wif.win_valid), 64'd1);
      chk_eq("hold_top", wif.win_top, sv_t);
      chk_eq("hold_mid", wif.win_mid, sv_m);
      chk_eq("hold_bot", wif.win_bot, sv_b);
    end
    wif.win_ready = !(hs_cnt == stall_at && stall_done < stall_len);
    if (wif.win_valid && !wif.win_ready) stall_done++;
    if (wif.win_valid && wif.win_ready) begin
      hs_cnt++;
      if (exp_win.size() == 0) chk("win_extra", 64'd1, 64'd0);
      else begin
        win_t e;
        e = exp_win.pop_front();
        chk_eq("win_top", wif.win_top, row_pat(e.t));
        chk_eq("win_mid", wif.win_mid, row_pat(e.m));
        chk_eq("win_bot", wif.win_bot, row_pat(e.b));
        pend.push_back(e.m);
      end
    end
    stalled = wif.win_valid && !wif.win_ready;
    sv_t = wif.win_top;
    sv_m = wif.win_mid;
    sv_b = wif.win_bot;
    if (pend.size() > 0) begin
      int k;
      k = pend.pop_front();
      wif.res_valid = 1'b1;
      wif.res_data  = res_pat(k);
      exp_wr.push_back(k);
    end else if (inject) begin
      wif.res_valid = 1'b1;
      wif.res_data  = res_pat(77);
    end else begin
      wif.res_valid = 1'b0;
      wif.res_data  = '0;
    end
  end

  task automatic exp_model(input int n);
    for (int r = 0; r < n; r++) begin
      win_t e;
      e.t = (r == 0) ? 0 : r - 1;
      e.m = r;
      e.b = (r + 1 < n) ? r + 1 : n - 1;
      exp_win.push_back(e);
      exp_rd.push_back(r);
    end
  endtask

  task automatic push_win(input int t, input int m, input int b);
    win_t e;
    e.t = t; e.m = m; e.b = b;
    exp_win.push_back(e);
  endtask

  task automatic go(input int n, input int budget);
    int d0, w0;
    d0 = done_cnt;
    w0 = dst_cnt;
    start = 1'b1;
    cfg_rows = ridx_t'(n);
    tick();
    start = 1'b0;
    cfg_rows = 7'd50;
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    chk("done_seen", 64'(done_cnt != d0), 64'd1);
    chk("busy_low_at_done", 64'(busy), 64'd0);
    tick();
    tick();
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    chk("dst_writes", 64'(dst_cnt - w0), 64'(n));
    chk("win_left", 64'(exp_win.size()), 64'd0);
    chk("rd_left", 64'(exp_rd.size()), 64'd0);
    chk("wr_left", 64'(exp_wr.size()), 64'd0);
  endtask

  initial begin
    int d0, h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_src_re", 64'(src_re), 64'd0);
    chk("rst_dst_we", 64'(dst_we), 64'd0);
    chk("rst_win_valid", 64'(wif.win_valid), 64'd0);
    chk("rst_win_regs", 64'(|{wif.win_top, wif.win_mid, wif.win_bot}), 64'd0);
    chk("rst_addrs", 64'({src_raddr, dst_waddr}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Four rows, hand-computed windows.
    push_win(0, 0, 1); push_win(0, 1, 2); push_win(1, 2, 3); push_win(2, 3, 3);
    for (int r = 0; r < 4; r++) exp_rd.push_back(r);
    go(4, 200);

    // Results while idle are dropped.
    d0 = dst_cnt;
    inject = 1'b1;
    tick();
    tick();
    inject = 1'b0;
    tick();
    tick();
    chk("idle_res_no_write", 64'(dst_cnt - d0), 64'd0);

    // Single row: one read, window (0,0,0).
    push_win(0, 0, 0);
    exp_rd.push_back(0);
    go(1, 100);

    // Zero rows: done next cycle, busy never rises.
    d0 = done_cnt;
    start = 1'b1;
    cfg_rows = '0;
    tick();
    start = 1'b0;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    tick();
    chk("zero_done_drop", 64'(done), 64'd0);
    chk("zero_busy_after", 64'(busy), 64'd0);
    chk("zero_done_once", 64'(done_cnt - d0), 64'd1);

    // Five rows, window r=2 stalled 5 cycles, start re-pulsed while busy.
    exp_model(5);
    stall_at = hs_cnt + 2;
    stall_len = 5;
    fork
      go(5, 300);
      begin
        for (int i = 0; i < 100 && stall_done < 1; i++) tick();
        chk("stall_reached", 64'(stall_done >= 1), 64'd1);
        start = 1'b1;
        cfg_rows = 7'd2;
        tick();
        start = 1'b0;
      end
    join
    chk("stall_cycles", 64'(stall_done), 64'd5);
    stall_at = -1;

    // Full image across all three banks.
    exp_model(96);
    go(96, 1500);

    // Asynchronous abort during r=2, then a clean pass.
    exp_model(6);
    h0 = hs_cnt;
    start = 1'b1;
    cfg_rows = 7'd6;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && hs_cnt - h0 < 2; i++) tick();
    chk("abort_r2_reached", 64'(hs_cnt - h0), 64'd2);
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_win_valid", 64'(wif.win_valid), 64'd0);
    chk("abort_src_re", 64'(src_re), 64'd0);
    chk("abort_dst_we", 64'(dst_we), 64'd0);
    chk("abort_win_regs", 64'(|{wif.win_top, wif.win_mid, wif.win_bot}), 64'd0);
    exp_win.delete();
    exp_rd.delete();
    exp_wr.delete();
    pend.delete();
    d0 = done_cnt;
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    exp_model(3);
    go(3, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
